// File: rtl/fmac_add_pipe_pkg.sv
// Shared FMAC datapath definitions: single-precision widths plus the
// addend-path widths and the final sign-magnitude resolution helper.
package fpu_defs_fmac;

    localparam int C_MANT      = 23;
    localparam int C_EXP       = 8;
    localparam int C_BIAS      = 127;
    localparam int C_ALIGN_W   = 75;
    localparam int C_ADD_SPLIT = 38;

    localparam int C_PP_W     = 2*C_MANT + 3;
    localparam int C_EXP_W    = C_EXP + 2;
    localparam int C_SUM_W    = C_ALIGN_W - 1;
    localparam int C_ADD_HI_W = C_ALIGN_W - C_ADD_SPLIT;

    typedef struct packed {
        logic [C_SUM_W-1:0] mant;
        logic               sign;
        logic               zero;
    } add_res_t;

    // Bit 74 of the raw sum is the sign; an exact zero from a subtraction is +0.
    function automatic add_res_t resolveResult(input logic [C_ALIGN_W-1:0] raw,
                                               input logic signPost,
                                               input logic sub);
        logic [C_ALIGN_W-1:0] mag;
        add_res_t             res;
        mag      = raw[C_ALIGN_W-1] ? (~raw + 1'b1) : raw;
        res.mant = mag[C_SUM_W-1:0];
        res.zero = (res.mant == '0);
        res.sign = raw[C_ALIGN_W-1] ? ~signPost : signPost;
        if (res.zero && sub) begin
            res.sign = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/fmac_add_pipe_csa.sv
// Parameterised-width 3:2 carry-save compressor; the carry vector is
// pre-shifted left by one and truncated to the operand width.
module csa_3to2 #(
    parameter int W = 75
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o,
    output logic [W-1:0] carry_o
);

    logic [W-1:0] majority;

    assign sum_o    = a_i ^ b_i ^ c_i;
    assign majority = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    assign carry_o  = {majority[W-2:0], 1'b0};

endmodule

// File: rtl/fmac_add_pipe.sv
// FMAC carry-save accumulation stage: 3:2 compress, carry-propagate add,
// sign-magnitude output. Define FMAC_ADD_SPLIT_EN for the two-stage split adder.
module fmac_add_pipe
    import fpu_defs_fmac::*;
(
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic                 Flush_SI,
    input  logic                 In_valid_SI,
    output logic                 In_ready_SO,
    input  logic [C_ALIGN_W-1:0] Mant_postalig_a_DI,
    input  logic [C_PP_W-1:0]    Pp_sum_DI,
    input  logic [C_PP_W-1:0]    Pp_carry_DI,
    input  logic [C_EXP_W-1:0]   Exp_postalig_DI,
    input  logic                 Sign_postalig_DI,
    input  logic                 Sub_SI,
    input  logic                 Sft_stop_SI,
    output logic                 Out_valid_SO,
    input  logic                 Out_ready_SI,
    output logic [C_SUM_W-1:0]   Mant_sum_DO,
    output logic [C_EXP_W-1:0]   Exp_DO,
    output logic                 Sign_DO,
    output logic                 Sft_stop_SO,
    output logic                 Zero_SO
);

    logic [C_ALIGN_W-1:0] opS, opC, csaX, csaY;
    logic                 outReady, accept;
    add_res_t             res;

    logic                 outValid_q, outValid_d;
    logic [C_SUM_W-1:0]   outMant_q;
    logic [C_EXP_W-1:0]   outExp_q;
    logic                 outSign_q, outSft_q, outZero_q;

    assign opS = {{(C_ALIGN_W-C_PP_W){1'b0}}, Pp_sum_DI};
    assign opC = {{(C_ALIGN_W-C_PP_W){1'b0}}, Pp_carry_DI};

    csa_3to2 #(.W(C_ALIGN_W)) u_csa (
        .a_i     (Mant_postalig_a_DI),
        .b_i     (opS),
        .c_i     (opC),
        .sum_o   (csaX),
        .carry_o (csaY)
    );

    assign outReady = ~outValid_q | Out_ready_SI;
    assign accept   = In_valid_SI & In_ready_SO;

`ifdef FMAC_ADD_SPLIT_EN
    logic                  s1Valid_q, s1Valid_d, s1Ready;
    logic [C_ADD_SPLIT-1:0] s1Low_q;
    logic                  s1Cout_q;
    logic [C_ADD_HI_W-1:0] s1XHi_q, s1YHi_q, hiSum;
    logic [C_EXP_W-1:0]    s1Exp_q;
    logic                  s1Sign_q, s1Sub_q, s1Sft_q;
    logic [C_ADD_SPLIT:0]  lowSum;

    assign lowSum = {1'b0, csaX[C_ADD_SPLIT-1:0]} + {1'b0, csaY[C_ADD_SPLIT-1:0]}
                  + {{C_ADD_SPLIT{1'b0}}, Sub_SI};
    assign hiSum  = s1XHi_q + s1YHi_q + {{(C_ADD_HI_W-1){1'b0}}, s1Cout_q};
    assign res    = resolveResult({hiSum, s1Low_q}, s1Sign_q, s1Sub_q);

    assign s1Ready     = ~s1Valid_q | outReady;
    assign In_ready_SO = s1Ready & ~Flush_SI;

    always_comb begin
        s1Valid_d  = s1Valid_q;
        outValid_d = outValid_q;
        if (Flush_SI) begin
            s1Valid_d  = 1'b0;
            outValid_d = 1'b0;
        end else begin
            if (s1Ready) s1Valid_d = In_valid_SI;
            if (outReady) outValid_d = s1Valid_q;
        end
    end

    // Stage 1 resolves the low half; stage 2 finishes the high half and sign-magnitude.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            s1Valid_q  <= 1'b0;
            s1Low_q    <= '0;
            s1Cout_q   <= 1'b0;
            s1XHi_q    <= '0;
            s1YHi_q    <= '0;
            s1Exp_q    <= '0;
            s1Sign_q   <= 1'b0;
            s1Sub_q    <= 1'b0;
            s1Sft_q    <= 1'b0;
            outValid_q <= 1'b0;
            outMant_q  <= '0;
            outExp_q   <= '0;
            outSign_q  <= 1'b0;
            outSft_q   <= 1'b0;
            outZero_q  <= 1'b0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            outValid_q <= outValid_d;
            if (accept) begin
                s1Low_q  <= lowSum[C_ADD_SPLIT-1:0];
                s1Cout_q <= lowSum[C_ADD_SPLIT];
                s1XHi_q  <= csaX[C_ALIGN_W-1:C_ADD_SPLIT];
                s1YHi_q  <= csaY[C_ALIGN_W-1:C_ADD_SPLIT];
                s1Exp_q  <= Exp_postalig_DI;
                s1Sign_q <= Sign_postalig_DI;
                s1Sub_q  <= Sub_SI;
                s1Sft_q  <= Sft_stop_SI;
            end
            if (outReady && s1Valid_q) begin
                outMant_q <= res.mant;
                outExp_q  <= s1Exp_q;
                outSign_q <= res.sign;
                outSft_q  <= s1Sft_q;
                outZero_q <= res.zero;
            end
        end
    end
`else
    logic [C_ALIGN_W-1:0] fullSum;

    assign fullSum     = csaX + csaY + {{(C_ALIGN_W-1){1'b0}}, Sub_SI};
    assign res         = resolveResult(fullSum, Sign_postalig_DI, Sub_SI);
    assign In_ready_SO = outReady & ~Flush_SI;

    always_comb begin
        outValid_d = outValid_q;
        if (Flush_SI) begin
            outValid_d = 1'b0;
        end else if (outReady) begin
            outValid_d = In_valid_SI;
        end
    end

    // Whole add and complement in one cycle straight into the output register.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            outValid_q <= 1'b0;
            outMant_q  <= '0;
            outExp_q   <= '0;
            outSign_q  <= 1'b0;
            outSft_q   <= 1'b0;
            outZero_q  <= 1'b0;
        end else begin
            outValid_q <= outValid_d;
            if (accept) begin
                outMant_q <= res.mant;
                outExp_q  <= Exp_postalig_DI;
                outSign_q <= res.sign;
                outSft_q  <= Sft_stop_SI;
                outZero_q <= res.zero;
            end
        end
    end
`endif

    assign Out_valid_SO = outValid_q;
    assign Mant_sum_DO  = outMant_q;
    assign Exp_DO       = outExp_q;
    assign Sign_DO      = outSign_q;
    assign Sft_stop_SO  = outSft_q;
    assign Zero_SO      = outZero_q;

endmodule
